ospi_host_ctrl: RTL and testbench



---
 rtl/ospi_host_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_ospi_host_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ospi_host_ctrl.sv
// Octal-SPI host controller: turns single read/write/erase requests into
// OSPI bus transactions (one byte per OSPI_CLK period, MSB-first address).
// Optional feature macro: OSPI_HOST_WREN_EN -- when defined, write and erase
// are preceded by a standalone WREN (0x06) transaction and a deselect gap.
module ospi_host_ctrl #(
  parameter int unsigned ADDR_BYTES   = 1,
  parameter int unsigned CLK_DIV      = 2,
  parameter int unsigned DUMMY_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [1:0]              req_op,
  input  logic [8*ADDR_BYTES-1:0] req_addr,
  input  logic [7:0]              req_wdata,
  output logic                    rsp_valid,
  output logic [7:0]              rsp_rdata,
  output logic                    rsp_err,
  output logic                    busy,
  output logic                    OSPI_CLK,
  output logic                    OSPI_CS,
  output logic [7:0]              OSPI_IO_O,
  output logic                    OSPI_IO_OE,
  input  logic [7:0]              OSPI_IO_I
);

  localparam int unsigned AW = 8 * ADDR_BYTES;
  localparam int unsigned DW = $clog2(2 * CLK_DIV) + 1;

  // Slot phase points: last low cycle, last cycle of a slot, last RECOVER cycle
  // (DONE already provides one deselect cycle, so RECOVER is one shorter).
  localparam logic [DW-1:0] DIV_RISE = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(2 * CLK_DIV - 1);
  localparam logic [DW-1:0] RCV_LAST = DW'(2 * CLK_DIV - 2);
  localparam logic [3:0]    CNT_ADDR = 4'(ADDR_BYTES);
  localparam logic [3:0]    CNT_DUMY = 4'(DUMMY_CYCLES);

  localparam logic [7:0] OPC_READ  = 8'h0B;
  localparam logic [7:0] OPC_WRITE = 8'h02;
  localparam logic [7:0] OPC_ERASE = 8'h20;
`ifdef OSPI_HOST_WREN_EN
  localparam logic [7:0] OPC_WREN  = 8'h06;
`endif

  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_ERASE, OP_RSVD} op_e;

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_WDATA, S_DONE, S_RECOVER
`ifdef OSPI_HOST_WREN_EN
    , S_WREN, S_GAP
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [3:0]      cnt_q, cnt_d;
  op_e             op_q, op_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [7:0]      cap_q, cap_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            slot_end;
  logic [7:0]      cmd_byte;

  assign slot_end = (div_q == DIV_LAST);

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      cap_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cap_q   <= cap_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: request capture, slot sequencing, byte/dummy counting.
  always_comb begin
    state_d = state_q;
    div_d   = slot_end ? '0 : div_q + 1'b1;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cap_d   = cap_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        div_d = '0;
        if (req_valid) begin
          op_d    = op_e'(req_op);
          addr_d  = req_addr;
          wdata_d = req_wdata;
          err_d   = (req_op == 2'b11);
          if (req_op == 2'b11) state_d = S_DONE;
`ifdef OSPI_HOST_WREN_EN
          else if (req_op == 2'b01 || req_op == 2'b10) state_d = S_WREN;
`endif
          else state_d = S_CMD;
        end
      end
`ifdef OSPI_HOST_WREN_EN
      S_WREN: if (slot_end) state_d = S_GAP;
      S_GAP:  if (slot_end) state_d = S_CMD;
`endif
      S_CMD: begin
        if (slot_end) begin
          state_d = S_ADDR;
          cnt_d   = CNT_ADDR;
        end
      end
      S_ADDR: begin
        if (slot_end) begin
          addr_d = addr_q << 8;
          cnt_d  = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            case (op_q)
              OP_READ: begin
                cnt_d   = CNT_DUMY;
                state_d = (DUMMY_CYCLES == 0) ? S_RDATA : S_DUMMY;
              end
              OP_WRITE: state_d = S_WDATA;
              default:  state_d = S_DONE;
            endcase
          end
        end
      end
      S_DUMMY: begin
        if (slot_end) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = S_RDATA;
        end
      end
      S_RDATA: begin
        if (div_q == DIV_RISE) cap_d = OSPI_IO_I;
        if (slot_end) begin
          rdata_d = cap_q;
          state_d = S_DONE;
        end
      end
      S_WDATA: if (slot_end) state_d = S_DONE;
      S_DONE: begin
        div_d   = '0;
        state_d = S_RECOVER;
      end
      S_RECOVER: begin
        div_d = div_q + 1'b1;
        if (div_q == RCV_LAST) begin
          div_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Opcode byte for the captured operation.
  always_comb begin
    cmd_byte = '0;
    case (op_q)
      OP_READ:  cmd_byte = OPC_READ;
      OP_WRITE: cmd_byte = OPC_WRITE;
      OP_ERASE: cmd_byte = OPC_ERASE;
      default:  cmd_byte = '0;
    endcase
  end

  // OSPI pin drive: CS/OE/IO per slot state, clock high in the second half-slot.
  always_comb begin
    OSPI_CS    = 1'b1;
    OSPI_CLK   = 1'b0;
    OSPI_IO_O  = '0;
    OSPI_IO_OE = 1'b0;
    case (state_q)
`ifdef OSPI_HOST_WREN_EN
      S_WREN: begin
        OSPI_CS    = 1'b0;
        OSPI_IO_OE = 1'b1;
        OSPI_IO_O  = OPC_WREN;
      end
`endif
      S_CMD: begin
        OSPI_CS    = 1'b0;
        OSPI_IO_OE = 1'b1;
        OSPI_IO_O  = cmd_byte;
      end
      S_ADDR: begin
        OSPI_CS    = 1'b0;
        OSPI_IO_OE = 1'b1;
        OSPI_IO_O  = addr_q[AW-1 -: 8];
      end
      S_WDATA: begin
        OSPI_CS    = 1'b0;
        OSPI_IO_OE = 1'b1;
        OSPI_IO_O  = wdata_q;
      end
      S_DUMMY, S_RDATA: OSPI_CS = 1'b0;
      default: ;
    endcase
    if (!OSPI_CS) OSPI_CLK = (div_q > DIV_RISE);
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = ~req_ready;
  assign rsp_valid = (state_q == S_DONE);
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_ospi_host_ctrl.sv
// Self-checking bench for ospi_host_ctrl: a default instance and one with
// ADDR_BYTES=3, CLK_DIV=1, DUMMY_CYCLES=0, driven from a vector table plus
// hand-written reset-abort and back-to-back sequences.
module tb_ospi_host_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        v0, v1, sel;
  logic [1:0]  req_op;
  logic [23:0] req_addr;
  logic [7:0]  req_wdata;
  logic [7:0]  fdata;
  logic [7:0]  fl_io;

  logic       rdy0, rv0, err0, busy0, ck0, cs0, oe0;
  logic [7:0] rd0, io0;
  logic       rdy1, rv1, err1, busy1, ck1, cs1, oe1;
  logic [7:0] rd1, io1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ospi_host_ctrl dut0 (
    .clk(clk), .reset_n(reset_n), .req_valid(v0), .req_ready(rdy0),
    .req_op(req_op), .req_addr(req_addr[7:0]), .req_wdata(req_wdata),
    .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(err0), .busy(busy0),
    .OSPI_CLK(ck0), .OSPI_CS(cs0), .OSPI_IO_O(io0), .OSPI_IO_OE(oe0),
    .OSPI_IO_I(fl_io)
  );

  ospi_host_ctrl #(.ADDR_BYTES(3), .CLK_DIV(1), .DUMMY_CYCLES(0)) dut3 (
    .clk(clk), .reset_n(reset_n), .req_valid(v1), .req_ready(rdy1),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(err1), .busy(busy1),
    .OSPI_CLK(ck1), .OSPI_CS(cs1), .OSPI_IO_O(io1), .OSPI_IO_OE(oe1),
    .OSPI_IO_I(fl_io)
  );

  // Observed instance selected by sel.
  logic       m_ready, m_rv, m_err, m_busy, m_clk, m_cs, m_oe;
  logic [7:0] m_rd, m_io;
  assign m_ready = sel ? rdy1  : rdy0;
  assign m_rv    = sel ? rv1   : rv0;
  assign m_err   = sel ? err1  : err0;
  assign m_busy  = sel ? busy1 : busy0;
  assign m_clk   = sel ? ck1   : ck0;
  assign m_cs    = sel ? cs1   : cs0;
  assign m_oe    = sel ? oe1   : oe0;
  assign m_rd    = sel ? rd1   : rd0;
  assign m_io    = sel ? io1   : io0;

  // Flash model: drives fdata only once the configured number of dummy
  // periods (rising OSPI_CLK with OE low) has elapsed, 0x3C otherwise.
  int   ne = 0;
  logic ne_prev = 1'b0;
  always @(posedge clk) begin
    ne_prev <= m_clk;
    if (m_cs) ne <= 0;
    else if (m_clk && !ne_prev && !m_oe) ne <= ne + 1;
  end
  assign fl_io = (!m_cs && ne == (sel ? 0 : 4)) ? fdata : 8'h3C;

  typedef struct {
    logic        sel;
    logic [1:0]  op;
    logic [23:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  fdata;
    int          rsp;
    int          rdy;
    int          cslow;
    int          falls;
    int          nb;
    logic [47:0] bytes;
    int          hiz;
    logic [7:0]  rdata;
    logic        err;
  } vec_t;

  vec_t vt[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int cs_low = 0, falls = 0, nb = 0, hiz = 0, unstable = 0;
    int rsp_cnt = 0, rsp_k = -1, rdy_k = -1, busy_bad = 0;
    logic [47:0] got = '0;
    logic [7:0]  rd = '0, prev_io = '0;
    logic        er = 1'b0, prev_cs = 1'b1, prev_clk = 1'b0;
    @(negedge clk);
    sel = v.sel; req_op = v.op; req_addr = v.addr; req_wdata = v.wdata; fdata = v.fdata;
    #1;
    check($sformatf("v%0d ready_idle", idx), 64'(m_ready), 64'd1);
    if (v.sel) v1 = 1'b1; else v0 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (k == 1) begin
        v0 = 1'b0; v1 = 1'b0;
        req_op = v.op ^ 2'b01; req_addr = ~v.addr; req_wdata = ~v.wdata;
      end
      if (!m_cs) cs_low++;
      if (!m_cs && prev_cs) falls++;
      if (m_clk && !prev_clk) begin
        if (m_oe) begin
          got = (got << 8) | 48'(m_io);
          nb++;
        end else if (!m_cs) hiz++;
      end
      if (m_clk && prev_clk && m_io != prev_io) unstable++;
      if (m_busy == m_ready) busy_bad++;
      if (m_rv) begin
        rsp_cnt++;
        if (rsp_k < 0) begin rsp_k = k; rd = m_rd; er = m_err; end
      end
      if (m_ready && rsp_k > 0 && rdy_k < 0) rdy_k = k;
      prev_cs = m_cs; prev_clk = m_clk; prev_io = m_io;
      if (rdy_k >= 0) break;
    end
    check($sformatf("v%0d rsp_cycle", idx),  64'(rsp_k),    64'(v.rsp));
    check($sformatf("v%0d rsp_rdata", idx),  64'(rd),       64'(v.rdata));
    check($sformatf("v%0d rsp_err", idx),    64'(er),       64'(v.err));
    check($sformatf("v%0d rsp_count", idx),  64'(rsp_cnt),  64'd1);
    check($sformatf("v%0d ready_cycle", idx), 64'(rdy_k),   64'(v.rdy));
    check($sformatf("v%0d cs_low", idx),     64'(cs_low),   64'(v.cslow));
    check($sformatf("v%0d cs_falls", idx),   64'(falls),    64'(v.falls));
    check($sformatf("v%0d nbytes", idx),     64'(nb),       64'(v.nb));
    check($sformatf("v%0d bytes", idx),      64'(got),      64'(v.bytes));
    check($sformatf("v%0d hiz_periods", idx), 64'(hiz),     64'(v.hiz));
    check($sformatf("v%0d io_stable", idx),  64'(unstable), 64'd0);
    check($sformatf("v%0d busy_inv", idx),   64'(busy_bad), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, rvc, first_k, fall_k, second_k, cs_low;
    logic first_err, err2;
    logic [7:0] rd2;
    logic prev_cs;

    //            sel   op     addr        wdata  fdata  rsp rdy cslow falls nb bytes              hiz rdata  err
    vt[0] = '{1'b0, 2'b00, 24'h000001, 8'h00, 8'hA5, 29, 33, 28, 1, 2, 48'h0B01,           5, 8'hA5, 1'b0};
    vt[1] = '{1'b0, 2'b00, 24'h0000FE, 8'h77, 8'h5C, 29, 33, 28, 1, 2, 48'h0BFE,           5, 8'h5C, 1'b0};
`ifdef OSPI_HOST_WREN_EN
    vt[2] = '{1'b0, 2'b01, 24'h000001, 8'hA5, 8'h00, 21, 25, 16, 2, 4, 48'h060201A5,       0, 8'h5C, 1'b0};
    vt[3] = '{1'b0, 2'b10, 24'h000010, 8'h00, 8'h00, 17, 21, 12, 2, 3, 48'h062010,         0, 8'h5C, 1'b0};
`else
    vt[2] = '{1'b0, 2'b01, 24'h000001, 8'hA5, 8'h00, 13, 17, 12, 1, 3, 48'h0201A5,         0, 8'h5C, 1'b0};
    vt[3] = '{1'b0, 2'b10, 24'h000010, 8'h00, 8'h00,  9, 13,  8, 1, 2, 48'h2010,           0, 8'h5C, 1'b0};
`endif
    vt[4] = '{1'b0, 2'b11, 24'h000033, 8'h11, 8'h00,  1,  5,  0, 0, 0, 48'h0,              0, 8'h5C, 1'b1};
    vt[5] = '{1'b1, 2'b00, 24'h123456, 8'h00, 8'h96, 11, 13, 10, 1, 4, 48'h0B123456,       1, 8'h96, 1'b0};
`ifdef OSPI_HOST_WREN_EN
    vt[6] = '{1'b1, 2'b01, 24'hABCDEF, 8'h42, 8'h00, 15, 17, 12, 2, 6, 48'h0602ABCDEF42,   0, 8'h96, 1'b0};
`else
    vt[6] = '{1'b1, 2'b01, 24'hABCDEF, 8'h42, 8'h00, 11, 13, 10, 1, 5, 48'h02ABCDEF42,     0, 8'h96, 1'b0};
`endif

    reset_n = 1'b0; v0 = 1'b0; v1 = 1'b0; sel = 1'b0;
    req_op = '0; req_addr = '0; req_wdata = '0; fdata = '0;
    repeat (3) @(negedge clk);
    check("rst cs",    64'(cs0),   64'd1);
    check("rst clk",   64'(ck0),   64'd0);
    check("rst oe",    64'(oe0),   64'd0);
    check("rst io",    64'(io0),   64'd0);
    check("rst ready", 64'(rdy0),  64'd1);
    check("rst busy",  64'(busy0), 64'd0);
    check("rst rv",    64'(rv0),   64'd0);
    check("rst rdata", 64'(rd0),   64'd0);
    check("rst err",   64'(err0),  64'd0);
    check("rst cs3",   64'(cs1),   64'd1);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(i, vt[i]);

    // Reset in the middle of a read: outputs drop back at once, no response.
    @(negedge clk);
    sel = 1'b0; req_op = 2'b00; req_addr = 24'h000001; fdata = 8'hA5; v0 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      v0 = 1'b0;
    end
    check("mid pre cs",  64'(cs0), 64'd0);
    check("mid pre clk", 64'(ck0), 64'd1);
    check("mid pre oe",  64'(oe0), 64'd1);
    reset_n = 1'b0;
    #1;
    check("mid cs",    64'(cs0),   64'd1);
    check("mid clk",   64'(ck0),   64'd0);
    check("mid oe",    64'(oe0),   64'd0);
    check("mid io",    64'(io0),   64'd0);
    check("mid ready", 64'(rdy0),  64'd1);
    check("mid busy",  64'(busy0), 64'd0);
    check("mid rdata", 64'(rd0),   64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    rvc = 0; cs_low = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rv0) rvc++;
      if (!cs0) cs_low++;
    end
    check("mid no_rsp", 64'(rvc),    64'd0);
    check("mid no_cs",  64'(cs_low), 64'd0);

    // Reserved op, then a read held on req_valid while busy.
    acc = 0; rvc = 0; first_k = -1; fall_k = -1; second_k = -1; cs_low = 0;
    first_err = 1'b0; err2 = 1'b1; rd2 = '0; prev_cs = 1'b1;
    @(negedge clk);
    sel = 1'b0; req_op = 2'b11; req_addr = 24'h000044; fdata = 8'hA5; v0 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) begin req_op = 2'b00; req_addr = 24'h000001; end
      if (v0 && rdy0) acc++;
      if (!cs0) cs_low++;
      if (!cs0 && prev_cs && fall_k < 0) fall_k = k;
      prev_cs = cs0;
      if (rv0) begin
        rvc++;
        if (rvc == 1) begin first_k = k; first_err = err0; end
        else if (rvc == 2) begin second_k = k; rd2 = rd0; err2 = err0; end
      end
      if (k == 6) v0 = 1'b0;
    end
    check("b2b rsvd_cycle", 64'(first_k),   64'd1);
    check("b2b rsvd_err",   64'(first_err), 64'd1);
    check("b2b accepts",    64'(acc),       64'd1);
    check("b2b cs_fall",    64'(fall_k),    64'd6);
    check("b2b cs_low",     64'(cs_low),    64'd28);
    check("b2b rd_cycle",   64'(second_k),  64'd34);
    check("b2b rd_data",    64'(rd2),       64'hA5);
    check("b2b rd_err",     64'(err2),      64'd0);
    check("b2b rsp_count",  64'(rvc),       64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
